// File: rtl/fsm_moore_prog.sv
// fsm_moore_prog: table-driven Moore machine whose next-state and output
// tables are loaded at runtime through a config write port. It adds a run
// enable, a saturating dwell counter and a one-cycle state-change pulse.
// Optional build macro FSM_MOORE_PROG_READBACK_EN adds the cfg_rdata port,
// which gives a registered read of the selected table entry.
module fsm_moore_prog #(
   parameter int ST_W        = 2,
   parameter int IN_W        = 2,
   parameter int OUT_W       = 2,
   parameter int RESET_STATE = 0,
   parameter int CNT_W       = 8
) (
   input  logic                                        clk,
   input  logic                                        reset,
   input  logic                                        en,
   input  logic [IN_W-1:0]                             in,
   input  logic                                        cfg_we,
   input  logic                                        cfg_sel,
   input  logic [ST_W+IN_W-1:0]                        cfg_addr,
   input  logic [((ST_W > OUT_W) ? ST_W : OUT_W)-1:0]  cfg_data,
`ifdef FSM_MOORE_PROG_READBACK_EN
   output logic [((ST_W > OUT_W) ? ST_W : OUT_W)-1:0]  cfg_rdata,
`endif
   output logic [OUT_W-1:0]                            out,
   output logic [ST_W-1:0]                             w_state,
   output logic                                        changed,
   output logic [CNT_W-1:0]                            dwell
);

   localparam int NSTATE = 2**ST_W;
   localparam int NCOL   = 2**IN_W;
   localparam int DW     = (ST_W > OUT_W) ? ST_W : OUT_W;

   // The next-state table is flattened and indexed by {state, in}, which is
   // the same layout as the config address.
   logic [ST_W-1:0]  ns_q  [NSTATE*NCOL];
   logic [OUT_W-1:0] out_q [NSTATE];

   logic [ST_W-1:0]  state_q, state_d;
   logic             changed_q, changed_d;
   logic [CNT_W-1:0] dwell_q;

   // Next state reads the table before any same-cycle write lands.
   always_comb begin
      state_d   = state_q;
      if (en) state_d = ns_q[{state_q, in}];
      changed_d = (state_d != state_q);
   end

   // State, change pulse and saturating dwell counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_W'(RESET_STATE);
         changed_q <= 1'b0;
         dwell_q   <= '0;
      end else begin
         state_q   <= state_d;
         changed_q <= changed_d;
         if (changed_d)
            dwell_q <= '0;
         else if (dwell_q != {CNT_W{1'b1}})
            dwell_q <= dwell_q + 1'b1;
      end
   end

   // Table storage. Reset makes every state a self-loop and clears all outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < NSTATE; s++) begin
            out_q[s] <= '0;
            for (int i = 0; i < NCOL; i++)
               ns_q[s*NCOL + i] <= ST_W'(s);
         end
      end else if (cfg_we) begin
         if (cfg_sel)
            out_q[cfg_addr[ST_W-1:0]] <= cfg_data[OUT_W-1:0];
         else
            ns_q[cfg_addr] <= cfg_data[ST_W-1:0];
      end
   end

`ifdef FSM_MOORE_PROG_READBACK_EN
   logic [DW-1:0] rdata_q, rdata_d;

   // The read mux samples the pre-write contents, so a same-address write returns the old value.
   always_comb begin
      rdata_d = '0;
      if (cfg_sel)
         rdata_d = DW'(out_q[cfg_addr[ST_W-1:0]]);
      else
         rdata_d = DW'(ns_q[cfg_addr]);
   end

   // Registered readback with one cycle of latency.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) rdata_q <= '0;
      else       rdata_q <= rdata_d;
   end

   assign cfg_rdata = rdata_q;
`endif

   assign out     = out_q[state_q];
   assign w_state = state_q;
   assign changed = changed_q;
   assign dwell   = dwell_q;

endmodule

// File: doc/fsm_moore_prog.md
Name: fsm_moore_prog

Overview:
- Parametrised, table-driven Moore state machine; the successor to the team's fixed 4-state/2-bit-input Moore FSMs.
- State count, input width and output width are parameters.
- Next-state and output tables are register arrays, loaded at runtime through a config write port.
- Adds run-enable, a dwell counter and a state-change pulse. Sits between board inputs (buttons/switches, already synchronised) and LED/7-seg drivers.

Parameters:
- ST_W, 2, state register width; number of states NS = 2**ST_W
- IN_W, 2, input vector width; columns per state = 2**IN_W
- OUT_W, 2, output vector width
- RESET_STATE, 0, state entered on reset (must be < NS)
- CNT_W, 8, dwell counter width

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- en  in  1  run enable; state advances only when 1
- in  in  IN_W  machine input
- cfg_we  in  1  table write strobe
- cfg_sel  in  1  0 = next-state table, 1 = output table
- cfg_addr  in  ST_W+IN_W  NS table: {state, in}; OUT table: low ST_W bits = state, upper bits ignored
- cfg_data  in  max(ST_W,OUT_W)  write data, LSB-aligned, excess bits ignored
- out  out  OUT_W  Moore output = OUT[state]
- w_state  out  ST_W  current state (debug)
- changed  out  1  one-cycle pulse, high in the cycle after a transition to a different state
- dwell  out  CNT_W  cycles spent in current state, saturating

Behaviour:
- Reset (async assert, takes effect immediately):
  - state = RESET_STATE
  - every NS[s][i] = s (self-loop)
  - every OUT[s] = 0
  - changed = 0, dwell = 0
  - hence out = 0
- out is purely combinational from state and OUT table; no dependency on in (strict Moore). out tracks OUT[state] with zero latency after an OUT write lands.
- Transition: on posedge clk with en = 1, state <= NS[state][in]. With en = 0, state holds and in is ignored.
- changed <= 1 iff en = 1 and NS[state][in] != state; otherwise 0. A self-loop never pulses.
- dwell:
  - changed transition clears it to 0.
  - Otherwise it increments by 1 each clock, regardless of en.
  - It saturates at 2**CNT_W - 1, with no wrap.
- Config write: on posedge clk with cfg_we = 1, the addressed entry is written; the new value is visible from the next cycle.
- Write and transition in the same cycle: the transition uses the pre-write table value. A write to NS[state][in] in that cycle does not affect that cycle's next state.
- Writes are allowed while running (en = 1); no lockout.
- cfg_we = 0: tables unchanged. cfg_data bits above the target width are discarded.
- Reset asserted mid-operation: tables return to their reset contents. Software must reload after any reset.
- State encoding: binary, all NS states legal, so there is no default/illegal branch.

Optional Feature:
- Macro: FSM_MOORE_PROG_READBACK_EN.
- Defined:
  - Adds port cfg_rdata (output, max(ST_W,OUT_W) bits).
  - cfg_rdata is a registered read of the entry selected by cfg_sel/cfg_addr, with 1-cycle latency and zero-extended.
  - A read and write to the same address in the same cycle returns the old value.
  - Reset value of cfg_rdata is 0.
- Undefined: port absent, no read mux. All other behaviour is identical.

Test Plan:
- Reset check: pulse reset asynchronously between clock edges -> state = 0, out = 0, changed = 0 and dwell = 0 immediately. With en = 1 and any in for 5 cycles -> state stays 0 (self-loops), dwell = 5.
- Load the classic table (NS row 0 = {3,0,0,1}, row 1 = {3,0,0,2}, row 2 = {0,1,1,2}, row 3 = {2,2,2,1}; OUT = {2,1,0,2}), then apply in sequence 3,3,0,1,0 -> states 1,2,0,0,3; out 1,0,2,2,2; changed pulses after the 1st, 2nd, 3rd and 5th edges only.
- en = 0 with in toggling for 10 cycles -> state frozen, changed = 0, dwell increments to 10. With CNT_W = 3 run 20 cycles -> dwell holds at 7.
- Same-cycle write: with state = 0 and in = 3, write NS[{0,3}] = 2 on the transition edge -> next state 1 (old value). Repeat from state 0 -> next state 2.
- OUT write while running: write OUT[current] = 3 -> out = 3 the next cycle with no state change and no changed pulse. Then assert reset mid-run -> OUT returns to 0 and NS to self-loops.
- READBACK_EN build: write NS[5] = 1, then read cfg_sel = 0, addr = 5 -> cfg_rdata = 1 one cycle later. Simultaneous read and write of OUT[2] = 3 -> old value returned, then 3 on the following read.
